// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart transmit scheduler.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    GAP
  } uart_sched_state_e;

  // Width needed to hold a frame length of frame_bits*clks_per_bit cycles.
  function automatic int frame_cnt_w(input int frame_bits, input int clks_per_bit);
    return $clog2(frame_bits * clks_per_bit + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req upward from ptr with wrap
// and grants the first requester found. Nothing is granted while en is low.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Priority search starting at ptr; the first hit wins, later hits are ignored.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        idx = IDX_W'((int'(ptr) + k) % N);
        if (!found && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = idx;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart transmitter among NUM_REQ byte
// producers. Accepts one byte per frame, pulses load then start, and holds
// off further grants for the frame time plus an inter-frame gap.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int FRAME_BITS   = 10,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [UART_DATA_W-1:0]         uart_data_o,
  output logic                           uart_byte_ready_o,
  output logic                           uart_t_byte_o,
  output logic                           busy_o,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id_o
);

  localparam int IDX_W        = $clog2(NUM_REQ);
  localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = frame_cnt_w(FRAME_BITS, CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  uart_sched_state_e      state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [UART_DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]       gid_q, gid_d;
  logic                   byte_ready_q, t_byte_q, busy_q;

  logic [NUM_REQ-1:0]     gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   xfer;
  logic [UART_DATA_W-1:0] req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data_i[g*UART_DATA_W +: UART_DATA_W];
  end

  // Arbitration only runs in IDLE, so ready is never offered mid-frame.
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid_i),
    .ptr     (ptr_q),
    .en      (state_q == IDLE),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready_o = gnt;
  // The arbiter only grants a requester that is valid, so any grant is a transfer.
  assign xfer        = |gnt;

  // Next-state, counter and capture logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    gid_d   = gid_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          data_d  = req_bytes[gnt_idx];
          gid_d   = gnt_idx;
          ptr_d   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d = LOAD;
        end
      end
      LOAD:  state_d = START;
      START: begin
        cnt_d   = FRAME_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            cnt_d   = GAP_LOAD;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, pointer and output registers; strobes decode the next state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      data_q       <= '0;
      gid_q        <= '0;
      byte_ready_q <= 1'b0;
      t_byte_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      data_q       <= data_d;
      gid_q        <= gid_d;
      byte_ready_q <= (state_d == LOAD);
      t_byte_q     <= (state_d == START);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign uart_data_o       = data_q;
  assign grant_id_o        = gid_q;
  assign uart_byte_ready_o = byte_ready_q;
  assign uart_t_byte_o     = t_byte_q;
  assign busy_o            = busy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a default build (4 requesters, 16 clk/bit,
// gap 2) and a fast build (1 clk/bit, no gap) driven from one initial block.
module tb_uart_tx_sched;

  localparam int FB        = 10;
  localparam int CPB       = 16;
  localparam int GAPC      = 2;
  localparam int SPACING   = 3 + FB * CPB + GAPC;  // load-to-load pulse distance
  localparam int BUSY_LEN  = 2 + FB * CPB + GAPC;  // LOAD + START + WAIT + GAP cycles
  localparam int SPACING_B = 3 + FB * 1 + 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  a_valid, a_ready, b_valid, b_ready;
  logic [31:0] a_data, b_data;
  logic [7:0]  a_udata, b_udata;
  logic        a_br, a_tb, a_busy, b_br, b_tb, b_busy;
  logic [1:0]  a_gid, b_gid;

  uart_tx_sched #(.NUM_REQ(4), .CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .GAP_CYCLES(GAPC)) dut_a (
    .clk_i(clk), .reset_i(rst), .req_valid_i(a_valid), .req_data_i(a_data),
    .req_ready_o(a_ready), .uart_data_o(a_udata), .uart_byte_ready_o(a_br),
    .uart_t_byte_o(a_tb), .busy_o(a_busy), .grant_id_o(a_gid)
  );

  uart_tx_sched #(.NUM_REQ(4), .CLKS_PER_BIT(1), .FRAME_BITS(FB), .GAP_CYCLES(0)) dut_b (
    .clk_i(clk), .reset_i(rst), .req_valid_i(b_valid), .req_data_i(b_data),
    .req_ready_o(b_ready), .uart_data_o(b_udata), .uart_byte_ready_o(b_br),
    .uart_t_byte_o(b_tb), .busy_o(b_busy), .grant_id_o(b_gid)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  int model_ptr = 0;

  function automatic int model_winner(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      int i = (p + k) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic push_expect(input logic [3:0] v, input logic [31:0] d, output int w);
    exp_t e;
    w = model_winner(v, model_ptr);
    e.id   = 2'(w);
    e.data = d[w*8 +: 8];
    sb.push_back(e);
    model_ptr = (w + 1) % 4;
  endtask

  task automatic do_reset();
    rst = 1'b1; a_valid = '0; b_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  // Waits (bounded) for dut_a to offer ready, then samples the LOAD and START cycles.
  task automatic run_frame(output bit got, output int waited, output logic [3:0] rdy,
                           output logic br, output logic [7:0] d, output logic [1:0] id,
                           output logic busy_ld, output logic br_at_start, output logic tb,
                           output int br_cyc);
    got = 0; waited = 0; rdy = '0; br = 0; d = '0; id = '0; busy_ld = 0;
    br_at_start = 0; tb = 0; br_cyc = 0;
    for (int n = 0; n < 400; n++) begin
      #1;
      if (a_ready !== 4'b0) begin
        got = 1; waited = n; rdy = a_ready;
        @(negedge clk); #1;
        br = a_br; d = a_udata; id = a_gid; busy_ld = a_busy; br_cyc = cyc;
        @(negedge clk); #1;
        tb = a_tb; br_at_start = a_br;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = '0; b_valid = '0; a_data = '0; b_data = '0;
    @(negedge clk); #1;
    tests_run++;
    if ({a_udata, a_br, a_tb, a_busy, a_gid, a_ready} !== 17'h0) begin
      tests_failed++;
      $display("FAIL reset_a: got %h want 0", {a_udata, a_br, a_tb, a_busy, a_gid, a_ready});
    end
    tests_run++;
    if ({b_udata, b_br, b_tb, b_busy, b_gid, b_ready} !== 17'h0) begin
      tests_failed++;
      $display("FAIL reset_b: got %h want 0", {b_udata, b_br, b_tb, b_busy, b_gid, b_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_single();
    bit got; int waited, w, br_cyc, fall_cyc, unstable;
    logic [3:0] rdy; logic br, busy_ld, br2, tb; logic [7:0] d; logic [1:0] id;
    exp_t e;
    a_data = 32'h0000_00AA; a_valid = 4'b0001;
    push_expect(a_valid, a_data, w);
    run_frame(got, waited, rdy, br, d, id, busy_ld, br2, tb, br_cyc);
    a_valid = '0;
    e = sb.pop_front();
    tests_run++;
    if (!got || rdy !== 4'b0001 || waited != 0) begin
      tests_failed++;
      $display("FAIL single_ready: got %b (wait %0d) want 0001 (wait 0)", rdy, waited);
    end
    tests_run++;
    if (br !== 1'b1 || br2 !== 1'b0 || tb !== 1'b1 || busy_ld !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_strobes: br=%b br_next=%b tb=%b busy=%b want 1 0 1 1", br, br2, tb, busy_ld);
    end
    tests_run++;
    if (d !== e.data || id !== e.id) begin
      tests_failed++;
      $display("FAIL single_data: got %h/%0d want %h/%0d", d, id, e.data, e.id);
    end
    unstable = 0; fall_cyc = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); #1;
      if (!a_busy) begin fall_cyc = cyc; break; end
      if (a_udata !== 8'hAA || a_gid !== 2'd0) unstable++;
    end
    tests_run++;
    if (fall_cyc - br_cyc != BUSY_LEN) begin
      tests_failed++;
      $display("FAIL single_busy_len: got %0d want %0d", fall_cyc - br_cyc, BUSY_LEN);
    end
    tests_run++;
    if (unstable != 0) begin
      tests_failed++;
      $display("FAIL single_hold: got %0d changes while busy want 0", unstable);
    end
  endtask

  task automatic test_round_robin();
    bit got; int waited, w, br_cyc, prev_cyc;
    logic [3:0] rdy; logic br, busy_ld, br2, tb; logic [7:0] d; logic [1:0] id;
    exp_t e;
    do_reset();
    a_data = 32'h1312_1110; a_valid = 4'b1111;
    prev_cyc = 0;
    for (int f = 0; f < 5; f++) begin
      push_expect(a_valid, a_data, w);
      run_frame(got, waited, rdy, br, d, id, busy_ld, br2, tb, br_cyc);
      e = sb.pop_front();
      tests_run++;
      if (!got || rdy !== (4'b0001 << w) || br !== 1'b1 || tb !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_frame%0d_strobes: ready=%b br=%b tb=%b want ready=%b br=1 tb=1",
                 f, rdy, br, tb, 4'b0001 << w);
      end
      tests_run++;
      if (d !== e.data || id !== e.id) begin
        tests_failed++;
        $display("FAIL rr_frame%0d_data: got %h/%0d want %h/%0d", f, d, id, e.data, e.id);
      end
      if (f > 0) begin
        tests_run++;
        if (br_cyc - prev_cyc != SPACING) begin
          tests_failed++;
          $display("FAIL rr_spacing%0d: got %0d want %0d", f, br_cyc - prev_cyc, SPACING);
        end
      end
      prev_cyc = br_cyc;
    end
  endtask

  task automatic test_ptr_wrap();
    bit got; int waited, w, br_cyc;
    logic [3:0] rdy; logic br, busy_ld, br2, tb; logic [7:0] d; logic [1:0] id;
    exp_t e;
    a_valid = 4'b1000;
    push_expect(a_valid, a_data, w);
    run_frame(got, waited, rdy, br, d, id, busy_ld, br2, tb, br_cyc);
    e = sb.pop_front();
    tests_run++;
    if (!got || id !== e.id || d !== e.data) begin
      tests_failed++;
      $display("FAIL wrap_serve3: got %0d/%h want %0d/%h", id, d, e.id, e.data);
    end
    a_valid = 4'b1001;
    push_expect(a_valid, a_data, w);
    run_frame(got, waited, rdy, br, d, id, busy_ld, br2, tb, br_cyc);
    e = sb.pop_front();
    tests_run++;
    if (!got || rdy !== 4'b0001 || id !== e.id || d !== e.data) begin
      tests_failed++;
      $display("FAIL wrap_next: got ready=%b %0d/%h want ready=0001 %0d/%h", rdy, id, d, e.id, e.data);
    end
  endtask

  task automatic test_wait_valid();
    bit got; int waited, w, br_cyc, ready_err, data_err;
    logic [3:0] rdy; logic br, busy_ld, br2, tb; logic [7:0] d; logic [1:0] id;
    logic [7:0] held;
    exp_t e;
    held = a_udata;
    a_valid = '0;
    repeat (50) @(negedge clk);
    a_data[23:16] = 8'h5C; a_valid = 4'b0100;
    ready_err = 0; data_err = 0; got = 0;
    for (int n = 0; n < 400; n++) begin
      #1;
      if (!a_busy) begin got = 1; break; end
      if (a_ready !== 4'b0) ready_err++;
      if (a_udata !== held) data_err++;
      @(negedge clk);
    end
    tests_run++;
    if (!got || ready_err != 0 || data_err != 0) begin
      tests_failed++;
      $display("FAIL wait_no_ready: idle=%0d ready_hits=%0d data_changes=%0d want 1 0 0", got, ready_err, data_err);
    end
    push_expect(a_valid, a_data, w);
    run_frame(got, waited, rdy, br, d, id, busy_ld, br2, tb, br_cyc);
    e = sb.pop_front();
    tests_run++;
    if (!got || waited != 0 || rdy !== 4'b0100 || id !== e.id || d !== e.data) begin
      tests_failed++;
      $display("FAIL wait_first_idle: wait=%0d ready=%b %0d/%h want 0 0100 %0d/%h",
               waited, rdy, id, d, e.id, e.data);
    end
  endtask

  task automatic test_async_reset();
    bit got; int waited, w, br_cyc;
    logic [3:0] rdy; logic br, busy_ld, br2, tb; logic [7:0] d; logic [1:0] id;
    exp_t e;
    a_valid = '0;
    repeat (50) @(negedge clk);
    #2;
    tests_run++;
    if (a_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_pre_busy: got %b want 1", a_busy);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({a_udata, a_br, a_tb, a_busy, a_gid, a_ready} !== 17'h0) begin
      tests_failed++;
      $display("FAIL areset_immediate: got %h want 0", {a_udata, a_br, a_tb, a_busy, a_gid, a_ready});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    a_data[31:24] = 8'h3D; a_valid = 4'b1100;
    push_expect(a_valid, a_data, w);
    run_frame(got, waited, rdy, br, d, id, busy_ld, br2, tb, br_cyc);
    e = sb.pop_front();
    tests_run++;
    if (!got || rdy !== 4'b0100 || id !== e.id || d !== e.data) begin
      tests_failed++;
      $display("FAIL areset_ptr0: got ready=%b %0d/%h want 0100 %0d/%h", rdy, id, d, e.id, e.data);
    end
    a_valid = '0;
  endtask

  task automatic test_fast_build();
    int w, prev_cyc, frames, stray;
    logic prev_br;
    exp_t e;
    b_data = 32'h0000_7700; b_valid = 4'b0010;
    prev_cyc = -1; frames = 0; stray = 0; prev_br = 1'b0;
    model_ptr = 0;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (b_ready !== 4'b0) push_expect(b_valid, b_data, w);
      if (prev_br) begin
        tests_run++;
        if (b_tb !== 1'b1) begin
          tests_failed++;
          $display("FAIL fast_tbyte%0d: got %b want 1", frames, b_tb);
        end
      end else if (b_tb !== 1'b0) begin
        stray++;
      end
      if (b_br === 1'b1) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL fast_unexpected_load: got pulse at cycle %0d want none", cyc);
        end else begin
          e = sb.pop_front();
          if (b_udata !== e.data || b_gid !== e.id) begin
            tests_failed++;
            $display("FAIL fast_data%0d: got %h/%0d want %h/%0d", frames, b_udata, b_gid, e.data, e.id);
          end
        end
        if (prev_cyc >= 0) begin
          tests_run++;
          if (cyc - prev_cyc != SPACING_B) begin
            tests_failed++;
            $display("FAIL fast_spacing%0d: got %0d want %0d", frames, cyc - prev_cyc, SPACING_B);
          end
        end
        prev_cyc = cyc;
        frames++;
        b_data[15:8] = b_data[15:8] + 8'h01;
      end
      prev_br = b_br;
      @(negedge clk);
    end
    b_valid = '0;
    tests_run++;
    if (frames < 4 || stray != 0) begin
      tests_failed++;
      $display("FAIL fast_frames: got %0d frames, %0d stray t_byte want >=4, 0", frames, stray);
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_wrap();
    test_wait_valid();
    test_async_reset();
    test_fast_build();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
